// File: rtl/uart_rx_os.sv
// 16x oversampling 8N1 UART receiver: synchronizer, start validation, 3-sample
// majority vote per bit, and a show-ahead byte FIFO with valid/rd handshake.
`timescale 1ns/1ps
module uart_rx_os #(
  parameter int CLK        = 50,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       res,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV = CLK * 1000000 / (BAUD_RATE * 16);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;

  // state | meaning
  // IDLE  | line high, waiting for a start edge
  // START | validating start bit at its centre
  // DATA  | sampling 8 data bits, LSB first
  // STOP  | sampling stop bit; push byte or flag framing error
  // BREAK | after framing error, wait for line to return high
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rxs_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      s_q, s_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [1:0]      smp_q, smp_d;
  logic            fe_q, fe_d;
  logic            ov_q, ov_d;
  logic            tick, dec, bit_v, push, pop, full, wr_en;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q, count_q;

  assign tick  = (cnt_q == CW'(DIV - 1));
  assign dec   = tick && (s_q == 4'd9);
  assign bit_v = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);

  assign valid = (count_q != '0);
  assign full  = (count_q == PW'(FIFO_DEPTH));
  assign pop   = rd && valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign wr_en = push && (!full || pop);
  assign data  = mem_q[rd_ptr_q[AW-1:0]];

  assign frame_err = fe_q;
  assign overrun   = ov_q;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      s_q       <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      smp_q     <= '0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s_q       <= s_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      smp_q     <= smp_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    s_d     = tick ? s_q + 4'd1 : s_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    smp_d   = smp_q;
    fe_d    = 1'b0;
    push    = 1'b0;
    if (tick && s_q == 4'd7) smp_d[0] = rxs_q;
    if (tick && s_q == 4'd8) smp_d[1] = rxs_q;
    case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d = START;
          cnt_d   = '0;
          s_d     = '0;
        end
      end
      START: begin
        if (dec) begin
          if (bit_v) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = 3'd0;
          end
        end
      end
      DATA: begin
        if (dec) begin
          shift_d[idx_q] = bit_v;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      STOP: begin
        if (dec) begin
          if (bit_v) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ov_d = push && full && !pop;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        wr_ptr_q                <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (wr_en && !pop)      count_q <= count_q + PW'(1);
      else if (!wr_en && pop) count_q <= count_q - PW'(1);
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at DIV=1 (16 clocks per bit): table of clean and
// glitch-preceded frames, then framing error, overrun, full+pop and reset-abort cases.
`timescale 1ns/1ps
module tb_uart_rx_os;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       rx  = 1'b1;
  logic       rd  = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, overrun;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  typedef struct {
    logic       glitch;
    logic [7:0] tx;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [5];

  uart_rx_os #(.CLK(1), .BAUD_RATE(62500), .FIFO_DEPTH(4)) dut (
    .clk(clk), .res(res), .rx(rx), .rd(rd),
    .data(data), .valid(valid), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // All drive tasks enter and leave 1 ns after a rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_raw(input logic [7:0] b, input logic stop_v, input int stop_bits);
    logic [8:0] f;
    f = {b, 1'b0};
    for (int i = 0; i < 9; i++) begin
      rx = f[i];
      cyc(16);
    end
    rx = stop_v;
    cyc(16 * stop_bits);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_raw(b, 1'b1, 1);
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp);
    @(negedge clk);
    chk({name, "_valid"}, valid, 1);
    chk({name, "_data"}, data, exp);
    @(posedge clk); #1;
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
  endtask

  initial begin
    int fe0, ov0;
    vecs[0] = '{1'b0, 8'hA5, 8'hA5};
    vecs[1] = '{1'b1, 8'h3C, 8'h3C};
    vecs[2] = '{1'b0, 8'h00, 8'h00};
    vecs[3] = '{1'b0, 8'hFF, 8'hFF};
    vecs[4] = '{1'b1, 8'h81, 8'h81};

    cyc(3);
    @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    cyc(1);
    res = 1'b1;
    cyc(5);

    for (int v = 0; v < 5; v++) begin
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      if (vecs[v].glitch) begin
        rx = 1'b0;
        cyc(4);
        rx = 1'b1;
        cyc(30);
        @(negedge clk);
        chk("glitch_no_valid", valid, 0);
        chk("glitch_no_fe", fe_cnt - fe0, 0);
        cyc(1);
      end
      send_frame(vecs[v].tx);
      cyc(2);
      @(negedge clk);
      chk("vec_valid", valid, 1);
      chk("vec_data", data, vecs[v].exp_data);
      cyc(5);
      @(negedge clk);
      chk("vec_data_stable", data, vecs[v].exp_data);
      cyc(1);
      rd = 1'b1;
      cyc(1);
      rd = 1'b0;
      @(negedge clk);
      chk("vec_empty_after_pop", valid, 0);
      chk("vec_no_fe", fe_cnt - fe0, 0);
      chk("vec_no_ov", ov_cnt - ov0, 0);
      cyc(1);
    end

    // Empty FIFO ignores rd.
    rd = 1'b1;
    cyc(2);
    rd = 1'b0;
    @(negedge clk);
    chk("rd_empty_ignored", valid, 0);
    cyc(1);

    // Stop bit held low for two bit periods.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_raw(8'h55, 1'b0, 2);
    cyc(20);
    @(negedge clk);
    chk("fe_pulse_count", fe_cnt - fe0, 1);
    chk("fe_no_valid", valid, 0);
    cyc(1);
    send_frame(8'h0F);
    cyc(2);
    pop_chk("after_fe", 8'h0F);
    @(negedge clk);
    chk("after_fe_single_pulse", fe_cnt - fe0, 1);
    chk("after_fe_no_ov", ov_cnt - ov0, 0);
    cyc(1);

    // Five back-to-back frames without reading: fifth dropped.
    ov0 = ov_cnt;
    for (int b = 1; b <= 5; b++) send_frame(8'(b));
    cyc(2);
    @(negedge clk);
    chk("overrun_count", ov_cnt - ov0, 1);
    cyc(1);
    for (int b = 1; b <= 4; b++) pop_chk("overrun_read", 8'(b));
    @(negedge clk);
    chk("overrun_drained", valid, 0);
    cyc(1);

    // Full FIFO with rd on the exact push cycle of the fifth byte
    // (push lands on the 157th rising edge after the start bit is driven).
    ov0 = ov_cnt;
    for (int b = 1; b <= 4; b++) send_frame(8'(b));
    fork
      send_frame(8'h05);
      begin
        repeat (156) @(posedge clk);
        #1 rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
      end
    join
    cyc(2);
    @(negedge clk);
    chk("full_pop_no_overrun", ov_cnt - ov0, 0);
    cyc(1);
    for (int b = 2; b <= 5; b++) pop_chk("full_pop_read", 8'(b));
    @(negedge clk);
    chk("full_pop_drained", valid, 0);
    cyc(1);

    // Reset during data bits, released while the line is high.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(8'h11);
    fork
      send_frame(8'hF0);
      begin
        cyc(40);
        res = 1'b0;
        cyc(50);
        res = 1'b1;
      end
    join
    cyc(20);
    @(negedge clk);
    chk("abort_no_valid", valid, 0);
    chk("abort_no_fe", fe_cnt - fe0, 0);
    chk("abort_no_ov", ov_cnt - ov0, 0);
    cyc(1);
    send_frame(8'hC3);
    cyc(2);
    pop_chk("after_abort", 8'hC3);
    @(negedge clk);
    chk("after_abort_empty", valid, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Oversampling UART receiver with a small byte FIFO, the receive-side companion to the team's 8N1 transmitter. It accepts a raw asynchronous serial line and synchronizes it, then validates the start bit and majority-votes each bit at 16x oversampling. Received bytes are delivered through a show-ahead FIFO with a valid/read handshake. It sits between the board RX pin and the command-parsing logic, replacing ad-hoc single-sample reception.

## Interface
- CLK, 50, system clock frequency in MHz.
- BAUD_RATE, 9600, line rate in bits/s.
- FIFO_DEPTH, 4, number of buffered bytes; power of two, ≥2.
- Derived DIV = CLK*1000000/(BAUD_RATE*16), integer division; must be ≥1. Bit period = 16*DIV clocks.
- clk  in  1  system clock, all logic on rising edge.
- res  in  1  reset, asynchronous, active-low; one clock domain only.
- rx  in  1  raw serial line, idle high, asynchronous to clk.
- rd  in  1  pop request; honoured only when valid=1.
- data  out  8  byte at FIFO head (show-ahead), LSB = first bit received.
- valid  out  1  FIFO not empty.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte completed while FIFO full, byte dropped.

## Operation
- rx passes through a 2-FF synchronizer; both flops reset to 1. All decisions use the synchronized value rxs.
- Tick generator: counter 0..DIV-1, tick when counter = DIV-1. Counter is cleared whenever IDLE detects a start edge. Sample index s (4 bits) counts ticks 0..15 within a bit.
- Bit value = majority of rxs at ticks s=7,8,9; decision taken on tick s=9.
- States:
  - IDLE: rxs=0 → clear tick counter and s, go START.
  - START: at s=9 decision, if bit=1 (false start/glitch) → IDLE, nothing reported; else → DATA, bit index 0.
  - DATA: at s=9 decision shift bit into shift register at position index, LSB first; index 7 → STOP. s wraps 15→0 per bit.
  - STOP: at s=9 decision, if bit=1 → push byte (or overrun pulse if full) → IDLE; if bit=0 → frame_err pulse, byte discarded → BREAK.
  - BREAK: wait for rxs=1, then IDLE; no start detection while rxs stays low.
- Return to IDLE occurs mid-stop-bit, so a following start edge is caught with ≤½ bit slack.
- FIFO: read pointer, write pointer and count of width log2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
  - Pop when rd && valid; rd while empty is ignored.
  - Push and pop in the same cycle when full: pop frees a slot, push accepted, no overrun, count unchanged.
  - Push and pop in the same cycle when neither empty nor full: count unchanged, order preserved.

## Timing
- Reset values: valid=0, data=0, frame_err=0, overrun=0, state IDLE, FIFO empty, shift register 0.
- Reset asserted mid-frame: immediate abort, FIFO flushed. After release, reception resumes only on a new high→low edge seen from IDLE. A line already low at release is treated as a start.
- Start-edge latency: 2 clocks (synchronizer) + 1 clock into START.
- Byte latency: valid rises the clock after the STOP-state decision tick, i.e. ≈9.6 bit periods after the start edge.
- frame_err/overrun assert exactly one clock, on the cycle following the STOP decision tick.
- data changes only on push-into-empty or pop; it is stable while valid=1 and rd=0.
- Glitch rejection: a low pulse shorter than 7 ticks plus synchronizer delay never produces a byte.

## Test plan
- Sim params CLK=1, BAUD_RATE=62500 (DIV=1, bit=16 clocks). Drive 8N1 frame 0xA5 → valid=1 with data=0xA5. Pulse rd → valid=0. No frame_err/overrun.
- rx low for 4 clocks then high → no valid, no error pulse, state returns to IDLE; a following frame 0x3C is received correctly.
- Frame 0x55 with stop bit driven low for 2 bit periods → one frame_err pulse, valid stays 0; line high then 0x0F frame → data=0x0F.
- Five back-to-back frames 0x01..0x05, rd=0 → one overrun pulse on the fifth. Reads return 0x01,0x02,0x03,0x04, then valid=0.
- FIFO full; assert rd on the exact cycle the fifth byte pushes → no overrun, reads yield 0x02..0x05.
- Assert res during the DATA bits of a frame, release mid-frame while the line is high → valid=0, no byte or error from the aborted frame. Next full frame 0xC3 → data=0xC3.
